// File: rtl/cp0_pkg.sv
// cp0_pkg: register numbers, exception codes and field positions for the CP0 interrupt responder.
package cp0_pkg;
  localparam logic [4:0] REG_SR = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC = 5'd14;
  localparam logic [4:0] REG_PRID = 5'd15;
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_t;
  localparam int IM_HI = 15;
  localparam int IM_LO = 10;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT = 0;
  localparam int IP_HI = 15;
  localparam int IP_LO = 10;
  localparam int BD_BIT = 31;
  localparam int EXC_HI = 6;
  localparam int EXC_LO = 2;
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
endpackage

// File: rtl/cp0_req_arb.sv
// cp0_req_arb: interrupt/exception request decision; an enabled interrupt outranks a same-cycle exception.
module cp0_req_arb
  import cp0_pkg::*;
(
  input  logic [5:0] i_hw_int,
  input  logic [5:0] i_im,
  input  logic       i_ie,
  input  logic       i_exl,
  input  logic [4:0] i_exc_code_in,
  output logic       o_int_req,
  output logic       o_exc_req,
  output logic [4:0] o_exc_code
);
  assign o_int_req = |(i_hw_int & i_im) & i_ie & ~i_exl;
  assign o_exc_req = (i_exc_code_in != 5'd0) & ~i_exl;
  assign o_exc_code = o_int_req ? EXC_INT : i_exc_code_in;
endmodule

// File: rtl/cp0_intc.sv
// cp0_intc: CP0 SR/Cause/EPC/PrID with interrupt/exception entry and eret.
// Optional CP0_BD_EN: record branch-delay state and restart delay-slot faults at the branch.
module cp0_intc
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0000_5000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic        EXLClr,
  input  logic [5:0]  HWInt,
  output logic        Req,
  output logic [31:0] EPC,
  output logic [31:0] DOut
);
  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc_code;
  logic [31:0] r_epc;
  logic        w_int_req;
  logic        w_exc_req;
  logic [4:0]  w_exc_code;
  logic        w_bd;
  logic [31:0] w_epc_src;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic        w_unused;

  cp0_req_arb u_arb (
    .i_hw_int      (HWInt),
    .i_im          (r_im),
    .i_ie          (r_ie),
    .i_exl         (r_exl),
    .i_exc_code_in (ExcCodeIn),
    .o_int_req     (w_int_req),
    .o_exc_req     (w_exc_req),
    .o_exc_code    (w_exc_code)
  );

`ifdef CP0_BD_EN
  assign w_bd = BDIn;
  assign w_epc_src = BDIn ? PC - 32'd4 : PC;
  assign w_unused = ^w_epc_src[1:0];
`else
  assign w_bd = 1'b0;
  assign w_epc_src = PC;
  assign w_unused = ^{w_epc_src[1:0], BDIn};
`endif

  assign Req = w_int_req | w_exc_req;
  assign EPC = r_epc;
  assign w_sr = {16'b0, r_im, 8'b0, r_exl, r_ie};
  assign w_cause = {r_bd, 15'b0, r_ip, 3'b0, r_exc_code, 2'b0};

  always_comb
    DOut = A1 == REG_SR    ? w_sr :
           A1 == REG_CAUSE ? w_cause :
           A1 == REG_EPC   ? r_epc :
           A1 == REG_PRID  ? PRID : 32'd0;

  // Entry outranks mtc0/eret: the instruction in M is flushed and must not commit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_im <= '0;
      r_exl <= 1'b0;
      r_ie <= 1'b0;
      r_bd <= 1'b0;
      r_ip <= '0;
      r_exc_code <= '0;
      r_epc <= '0;
    end else begin
      r_ip <= HWInt;
      if (Req) begin
        r_exl <= 1'b1;
        r_exc_code <= w_exc_code;
        r_epc <= {w_epc_src[31:2], 2'b00};
        r_bd <= w_bd;
      end else begin
        if (WE && A2 == REG_SR) begin
          r_im <= DIn[IM_HI:IM_LO];
          r_ie <= DIn[IE_BIT];
          r_exl <= DIn[EXL_BIT] & ~EXLClr;
        end else if (EXLClr) begin
          r_exl <= 1'b0;
        end
        if (WE && A2 == REG_EPC) r_epc <= {DIn[31:2], 2'b00};
      end
    end
  end
endmodule

// File: tb/tb_cp0_intc.sv
// tb_cp0_intc: directed stimulus with a word-level CP0 model checked every cycle, plus literal checks.
module tb_cp0_intc;
`ifdef CP0_BD_EN
  localparam bit BD_EN = 1'b1;
`else
  localparam bit BD_EN = 1'b0;
`endif
  logic CLK = 0, RST = 1, WE = 0, BDIn = 0, EXLClr = 0;
  logic [4:0] A1 = 0, A2 = 0, ExcCodeIn = 0;
  logic [31:0] DIn = 0, PC = 0;
  logic [5:0] HWInt = 0;
  logic Req;
  logic [31:0] EPC, DOut;
  int n_tests = 0, n_fail = 0;
  logic [31:0] m_sr = 0, m_cause = 0, m_epc = 0, m_src;
  bit m_ir, m_er;

  cp0_intc dut (
    .CLK(CLK), .RST(RST), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE), .PC(PC),
    .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .EXLClr(EXLClr), .HWInt(HWInt),
    .Req(Req), .EPC(EPC), .DOut(DOut)
  );

  always #5 CLK = ~CLK;

  function automatic bit m_int();
    return (|(HWInt & m_sr[15:10])) & m_sr[0] & ~m_sr[1];
  endfunction
  function automatic bit m_exc();
    return (ExcCodeIn != 0) & ~m_sr[1];
  endfunction
  function automatic logic [31:0] m_read(input logic [4:0] a);
    return a == 12 ? m_sr : a == 13 ? m_cause : a == 14 ? m_epc : a == 15 ? 32'h0000_5000 : 32'd0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin
    if (RST) begin
      m_sr = 0;
      m_cause = 0;
      m_epc = 0;
    end else begin
      m_ir = m_int();
      m_er = m_exc();
      if (m_ir || m_er) begin
        m_src = (BD_EN && BDIn) ? PC - 4 : PC;
        m_cause = {BD_EN & BDIn, 15'b0, HWInt, 3'b0, m_ir ? 5'd0 : ExcCodeIn, 2'b0};
        m_sr[1] = 1'b1;
        m_epc = m_src & ~32'h3;
      end else begin
        if (WE && A2 == 12) m_sr = DIn & 32'h0000_FC03;
        if (WE && A2 == 14) m_epc = DIn & ~32'h3;
        if (EXLClr) m_sr[1] = 1'b0;
        m_cause[15:10] = HWInt;
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      chk("model_req", {31'b0, Req}, {31'b0, m_int() | m_exc()});
      chk("model_epc", EPC, m_epc);
      chk("model_dout", DOut, m_read(A1));
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  task automatic rd(input string nm, input logic [4:0] a, input logic [31:0] exp);
    A1 = a;
    #1;
    chk(nm, DOut, exp);
  endtask
  task automatic req_is(input string nm, input logic exp);
    #1;
    chk(nm, {31'b0, Req}, {31'b0, exp});
  endtask

  initial begin
    repeat (2) cyc();
    RST = 0;
    rd("rst_sr", 12, 0); rd("rst_cause", 13, 0); rd("rst_epc", 14, 0);
    rd("rst_prid", 15, 32'h0000_5000); rd("rst_unmapped", 3, 0);
    req_is("rst_req", 0);
    // interrupt entry
    WE = 1; A2 = 12; DIn = 32'h0000_0401; cyc(); WE = 0;
    rd("sr_written", 12, 32'h0000_0401);
    HWInt = 6'd1; PC = 32'h0000_3010; req_is("irq_req", 1);
    cyc();
    req_is("irq_blocked", 0);
    rd("irq_sr", 12, 32'h0000_0403); rd("irq_epc", 14, 32'h0000_3010); rd("irq_cause", 13, 32'h0000_0400);
    chk("irq_epc_port", EPC, 32'h0000_3010);
    // eret with IRQ still high re-requests
    EXLClr = 1; req_is("eret_cycle_req", 0); cyc(); EXLClr = 0;
    req_is("eret_rerequest", 1); rd("eret_sr", 12, 32'h0000_0401);
    HWInt = 0; req_is("irq_dropped", 0);
    cyc();
    // interrupt beats exception
    HWInt = 6'd1; ExcCodeIn = 12; PC = 32'h0000_3020; req_is("both_req", 1);
    cyc(); ExcCodeIn = 0;
    rd("both_cause", 13, 32'h0000_0400); chk("both_epc", EPC, 32'h0000_3020);
    HWInt = 0; EXLClr = 1; cyc(); EXLClr = 0;
    // masked IRQ with overflow
    WE = 1; A2 = 12; DIn = 32'h0000_0001; cyc(); WE = 0;
    HWInt = 6'd1; req_is("masked_no_req", 0);
    ExcCodeIn = 12; PC = 32'h0000_3036; req_is("ov_req", 1);
    cyc(); ExcCodeIn = 0;
    rd("ov_cause", 13, 32'h0000_0430); chk("ov_epc", EPC, 32'h0000_3034);
    HWInt = 0; EXLClr = 1; cyc(); EXLClr = 0;
    // mtc0 EPC collides with entry
    ExcCodeIn = 4; PC = 32'h0000_3040; WE = 1; A2 = 14; DIn = 32'h1234_5677; req_is("coll_req", 1);
    cyc(); ExcCodeIn = 0;
    chk("coll_epc", EPC, 32'h0000_3040); rd("coll_cause", 13, 32'h0000_0010);
    EXLClr = 1; req_is("coll_eret_req", 0);
    cyc(); WE = 0; EXLClr = 0;
    chk("epc_write", EPC, 32'h1234_5674); rd("sr_after_eret", 12, 32'h0000_0001);
    // SR write and eret together: eret owns EXL
    ExcCodeIn = 5; PC = 32'h0000_3050; cyc(); ExcCodeIn = 0;
    rd("ades_sr", 12, 32'h0000_0003);
    WE = 1; A2 = 12; DIn = 32'hFFFF_FFFF; EXLClr = 1; cyc(); EXLClr = 0;
    rd("sr_exlclr_wins", 12, 32'h0000_FC01);
    A2 = 13; cyc(); A2 = 15; cyc(); WE = 0;
    rd("cause_ro", 13, 32'h0000_0014); rd("prid_ro", 15, 32'h0000_5000); rd("unmapped", 9, 0);
    // delay-slot fault
    BDIn = 1; ExcCodeIn = 10; PC = 32'h0000_3008; req_is("bd_req", 1);
    cyc(); BDIn = 0; ExcCodeIn = 0;
    chk("bd_epc", EPC, BD_EN ? 32'h0000_3004 : 32'h0000_3008);
    rd("bd_cause", 13, BD_EN ? 32'h8000_0028 : 32'h0000_0028);
    // reset inside the handler
    RST = 1; cyc(); RST = 0;
    rd("rst2_sr", 12, 0); rd("rst2_cause", 13, 0); chk("rst2_epc", EPC, 0);
    repeat (2) cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
